// File: rtl/uart_rx_os_framer.sv
// UART receiver with 3-point majority-vote oversampling, optional parity and
// a FIFO-facing write strobe. Frames are checked at the stop-bit vote and
// produce exactly one of: write strobe, frame error, parity error, overrun.
module uart_rx_os_framer #(
   parameter int CLKS_PER_BIT = 217,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_Rx_Serial,
   input  logic       wr_ready,
   input  logic       full,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Done,
   output logic       o_CTS,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t CNT_HM1  = cnt_t'(H - 1);
   localparam cnt_t CNT_H    = cnt_t'(H);
   localparam cnt_t CNT_VOTE = cnt_t'(H + 1);
   localparam cnt_t CNT_LAST = cnt_t'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic       rx_meta, rx_s;
   logic [1:0] sync_fill;
   state_t     state, state_next;
   cnt_t       clk_cnt, cnt_next;
   logic [2:0] bit_idx, idx_next;
   logic [7:0] shift_reg, shift_next;
   logic [1:0] samp, samp_next;
   logic       par_bad, par_bad_next;
   logic       armed, armed_next;
   logic [7:0] byte_next;
   logic       done_next, ferr_next, perr_next, ovr_next;
   logic       vote, at_vote, at_last;

   // Two-flop synchronizer; sync_fill marks when rx_s reflects the real line
   // rather than the forced-high reset value.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         sync_fill <= 2'b00;
      end else begin
         rx_meta   <= i_Rx_Serial;
         rx_s      <= rx_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   assign vote    = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
   assign at_vote = (clk_cnt == CNT_VOTE);
   assign at_last = (clk_cnt == CNT_LAST);

   // Next-state, datapath and registered-output decode.
   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      state_next   = state;
      cnt_next     = clk_cnt + cnt_t'(1);
      idx_next     = bit_idx;
      shift_next   = shift_reg;
      samp_next    = samp;
      par_bad_next = par_bad;
      armed_next   = armed;
      byte_next    = o_RX_Byte;
      done_next    = 1'b0;
      ferr_next    = 1'b0;
      perr_next    = 1'b0;
      ovr_next     = 1'b0;

      if (clk_cnt == CNT_HM1) samp_next[0] = rx_s;
      if (clk_cnt == CNT_H)   samp_next[1] = rx_s;

      case (state)
         IDLE: begin
            cnt_next = '0;
            // A start is only accepted once the line has been seen idle-high,
            // which keeps a break or a reset mid-frame from faking a start.
            if (sync_fill[1] && rx_s) armed_next = 1'b1;
            if (armed && !rx_s) begin
               state_next   = START;
               par_bad_next = 1'b0;
            end
         end
         START: begin
            if (at_vote && vote) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (at_last) begin
               state_next = DATA;
               cnt_next   = '0;
               idx_next   = '0;
            end
         end
         DATA: begin
            if (at_vote) shift_next[bit_idx] = vote;
            if (at_last) begin
               cnt_next = '0;
               if (bit_idx == 3'd7) begin
                  state_next = PARITY_EN ? PARITY : STOP;
                  idx_next   = '0;
               end else begin
                  idx_next = bit_idx + 3'd1;
               end
            end
         end
         PARITY: begin
            if (at_vote) par_bad_next = vote ^ (^shift_reg) ^ PARITY_ODD;
            if (at_last) begin
               state_next = STOP;
               cnt_next   = '0;
            end
         end
         STOP: begin
            // Decide at the vote and release immediately so a following start
            // bit is never missed.
            if (at_vote) begin
               state_next = IDLE;
               cnt_next   = '0;
               if (!vote) begin
                  ferr_next  = 1'b1;
                  armed_next = 1'b0;
               end else if (PARITY_EN && par_bad) begin
                  perr_next = 1'b1;
               end else if (!wr_ready || full) begin
                  ovr_next = 1'b1;
               end else begin
                  done_next = 1'b1;
                  byte_next = shift_reg;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // FSM, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         samp         <= 2'b11;
         par_bad      <= 1'b0;
         armed        <= 1'b0;
         o_RX_Byte    <= 8'h00;
         o_RX_Done    <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
         o_busy       <= 1'b0;
         o_CTS        <= 1'b0;
      end else begin
         state        <= state_next;
         clk_cnt      <= cnt_next;
         bit_idx      <= idx_next;
         shift_reg    <= shift_next;
         samp         <= samp_next;
         par_bad      <= par_bad_next;
         armed        <= armed_next;
         o_RX_Byte    <= byte_next;
         o_RX_Done    <= done_next;
         o_frame_err  <= ferr_next;
         o_parity_err <= perr_next;
         o_overrun    <= ovr_next;
         o_busy       <= (state_next != IDLE);
         o_CTS        <= wr_ready & ~full;
      end
   end

endmodule

// File: tb/tb_uart_rx_os_framer.sv
// Bench for uart_rx_os_framer: an 8N1 and an 8E1 instance on separate lines,
// a frame-level outcome model with an expected-event queue, and one compare
// process that checks pulses, held byte, CTS and reset values every cycle.
`timescale 1ns/1ps
module tb_uart_rx_os_framer;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
   // Stop-bit start (as seen past the 2-flop synchronizer) to visible pulse.
   localparam int LAT_SYNC = H + 1 + 2;

   typedef enum int {EV_DONE, EV_FERR, EV_PERR, EV_OVR} ev_kind_t;
   typedef struct {
      int       inst;
      ev_kind_t kind;
      logic [7:0] data;
      int       cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_ready = 1'b1;
   logic       full = 1'b0;
   logic       rx_line [2];
   logic [7:0] rx_byte [2];
   logic       done [2], cts [2], ferr [2], perr [2], ovr [2], busy [2];

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   ev_t        exp_q[$];
   logic [7:0] model_byte [2];
   logic       cts_model;

   uart_rx_os_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_8n1 (
      .clk(clk), .rst(rst), .i_Rx_Serial(rx_line[0]), .wr_ready(wr_ready), .full(full),
      .o_RX_Byte(rx_byte[0]), .o_RX_Done(done[0]), .o_CTS(cts[0]), .o_frame_err(ferr[0]),
      .o_parity_err(perr[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));

   uart_rx_os_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_8e1 (
      .clk(clk), .rst(rst), .i_Rx_Serial(rx_line[1]), .wr_ready(wr_ready), .full(full),
      .o_RX_Byte(rx_byte[1]), .o_RX_Done(done[1]), .o_CTS(cts[1]), .o_frame_err(ferr[1]),
      .o_parity_err(perr[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Clear-to-send is the FIFO's willingness one clock late.
   always @(posedge clk or posedge rst) begin
      if (rst) cts_model <= 1'b0;
      else     cts_model <= wr_ready & ~full;
   end

   task automatic check(input string name, input bit ok, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
      end
   endtask

   function automatic int find_head(input int inst);
      for (int k = 0; k < exp_q.size(); k++)
         if (exp_q[k].inst == inst) return k;
      return -1;
   endfunction

   function automatic logic [3:0] kind_vec(input ev_kind_t k);
      case (k)
         EV_DONE: return 4'b1000;
         EV_FERR: return 4'b0100;
         EV_PERR: return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   task automatic compare_inst(input int i);
      logic [3:0] p;
      int idx;
      p = {done[i], ferr[i], perr[i], ovr[i]};
      if (rst) begin
         model_byte[i] = 8'h00;
         for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].inst == i) exp_q.delete(k);
         check($sformatf("reset_outputs[%0d]", i), {rx_byte[i], p, busy[i], cts[i]} == 14'h0,
               int'({rx_byte[i], p, busy[i], cts[i]}), 0);
         return;
      end
      idx = find_head(i);
      if (p != 4'b0000) begin
         check($sformatf("spurious_pulse[%0d]", i), idx >= 0, int'(p), 0);
         if (idx >= 0) begin
            check($sformatf("pulse_kind[%0d]", i), p == kind_vec(exp_q[idx].kind),
                  int'(p), int'(kind_vec(exp_q[idx].kind)));
            check($sformatf("pulse_time[%0d]", i),
                  cyc >= exp_q[idx].cyc - 1 && cyc <= exp_q[idx].cyc + 1, cyc, exp_q[idx].cyc);
            if (exp_q[idx].kind == EV_DONE) model_byte[i] = exp_q[idx].data;
            exp_q.delete(idx);
         end
      end else if (idx >= 0) begin
         check($sformatf("pulse_deadline[%0d]", i), cyc <= exp_q[idx].cyc + 1, cyc, exp_q[idx].cyc);
         if (cyc > exp_q[idx].cyc + 1) exp_q.delete(idx);
      end
      check($sformatf("rx_byte[%0d]", i), rx_byte[i] == model_byte[i], int'(rx_byte[i]), int'(model_byte[i]));
      check($sformatf("cts[%0d]", i), cts[i] == cts_model, int'(cts[i]), int'(cts_model));
   endtask

   // One compare process, away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) compare_inst(i);
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame on instance i's line. The expected outcome comes from the
   // frame rules: stop low > parity wrong > FIFO not ready > good byte.
   // abort_pos >= 0 pulses reset in the middle of that bit position.
   task automatic send_frame(input int i, input logic [7:0] d, input bit par_bit,
                             input bit stop_bit, input int abort_pos);
      logic [10:0] bits;
      int n;
      bit aborted;
      ev_t e;
      aborted = 1'b0;
      bits = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = d[k];
      n = 9;
      if (i == 1) begin
         bits[9] = par_bit;
         n = 10;
      end
      bits[n] = stop_bit;
      n = n + 1;
      for (int k = 0; k < n; k++) begin
         if (k == n - 1 && !aborted) begin
            e.inst = i;
            e.data = d;
            e.cyc  = cyc + 2 + LAT_SYNC;
            if (!stop_bit)                      e.kind = EV_FERR;
            else if (i == 1 && par_bit != ^d)   e.kind = EV_PERR;
            else if (!wr_ready || full)         e.kind = EV_OVR;
            else                                e.kind = EV_DONE;
            exp_q.push_back(e);
         end
         rx_line[i] = bits[k];
         if (k == abort_pos) begin
            wait_cyc(CPB / 2);
            rst = 1'b1;
            aborted = 1'b1;
            wait_cyc(3);
            rst = 1'b0;
            wait_cyc(CPB - CPB / 2 - 3);
         end else begin
            wait_cyc(CPB);
         end
      end
      rx_line[i] = 1'b1;
   endtask

   initial begin
      int busy_cnt;
      int gap;
      int inst;
      bit last_bad;
      logic [7:0] d;
      bit stop_bit;
      rx_line[0] = 1'b1;
      rx_line[1] = 1'b1;
      model_byte[0] = 8'h00;
      model_byte[1] = 8'h00;
      wait_cyc(5);
      check("reset_byte_literal", rx_byte[0] == 8'h00 && busy[0] == 1'b0, int'(rx_byte[0]), 0);
      rst = 1'b0;
      wait_cyc(10);

      // Plain 8N1 frame.
      send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
      wait_cyc(20);
      check("byte_a5_literal", rx_byte[0] == 8'hA5, int'(rx_byte[0]), 8'hA5);
      check("busy_idle", busy[0] == 1'b0, int'(busy[0]), 0);

      // Short low glitch on an idle line is a false start.
      rx_line[0] = 1'b0;
      wait_cyc(5);
      rx_line[0] = 1'b1;
      busy_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy[0]) busy_cnt++;
      end
      @(posedge clk);
      #1;
      check("glitch_busy_cycles", busy_cnt > 0 && busy_cnt <= 12, busy_cnt, 12);

      // Bad stop bit keeps the old byte, next good frame recovers.
      send_frame(0, 8'h3C, 1'b0, 1'b0, -1);
      wait_cyc(20);
      check("byte_kept_after_ferr", rx_byte[0] == 8'hA5, int'(rx_byte[0]), 8'hA5);
      send_frame(0, 8'h11, 1'b0, 1'b1, -1);
      wait_cyc(20);
      check("byte_11_literal", rx_byte[0] == 8'h11, int'(rx_byte[0]), 8'h11);

      // Even parity: 0x07 has three ones, so the parity bit must be 1.
      send_frame(1, 8'h07, 1'b0, 1'b1, -1);
      wait_cyc(20);
      check("byte_kept_after_perr", rx_byte[1] == 8'h00, int'(rx_byte[1]), 8'h00);
      send_frame(1, 8'h07, 1'b1, 1'b1, -1);
      wait_cyc(20);
      check("byte_07_literal", rx_byte[1] == 8'h07, int'(rx_byte[1]), 8'h07);

      // FIFO full: CTS drops, frame ends in overrun.
      check("cts_before_full", cts[0] == 1'b1, int'(cts[0]), 1);
      full = 1'b1;
      wait_cyc(2);
      check("cts_after_full", cts[0] == 1'b0, int'(cts[0]), 0);
      send_frame(0, 8'h55, 1'b0, 1'b1, -1);
      full = 1'b0;
      wait_cyc(20);
      check("byte_kept_after_overrun", rx_byte[0] == 8'h11, int'(rx_byte[0]), 8'h11);

      // Break: line stays low well past the stop bit; one frame error only.
      send_frame(0, 8'h00, 1'b0, 1'b0, -1);
      rx_line[0] = 1'b0;
      wait_cyc(3 * CPB);
      rx_line[0] = 1'b1;
      wait_cyc(20);
      send_frame(0, 8'h5A, 1'b0, 1'b1, -1);
      wait_cyc(20);
      check("byte_5a_after_break", rx_byte[0] == 8'h5A, int'(rx_byte[0]), 8'h5A);

      // Reset in the middle of data bit 4 (frame position 5).
      send_frame(0, 8'hFF, 1'b0, 1'b1, 5);
      wait_cyc(20);
      check("byte_cleared_by_reset", rx_byte[0] == 8'h00, int'(rx_byte[0]), 8'h00);
      send_frame(0, 8'h81, 1'b0, 1'b1, -1);
      wait_cyc(20);
      check("byte_81_literal", rx_byte[0] == 8'h81, int'(rx_byte[0]), 8'h81);

      // Randomized frames on both instances.
      last_bad = 1'b0;
      for (int n = 0; n < 60; n++) begin
         inst     = int'($urandom_range(0, 1));
         d        = 8'($urandom);
         stop_bit = ($urandom_range(0, 7) != 0);
         wr_ready = ($urandom_range(0, 5) != 0);
         full     = ($urandom_range(0, 5) == 0);
         gap      = int'($urandom_range(0, 12)) + (last_bad ? 4 : 0);
         wait_cyc(gap);
         send_frame(inst, d, (^d) ^ ($urandom_range(0, 5) == 0), stop_bit, -1);
         last_bad = !stop_bit;
      end
      wr_ready = 1'b1;
      full = 1'b0;

      for (int t = 0; t < 200 && exp_q.size() > 0; t++) wait_cyc(1);
      check("events_drained", exp_q.size() == 0, exp_q.size(), 0);
      wait_cyc(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
